// File: rtl/axis_golden_checker.sv
// axis_golden_checker: lock-step compare of a 64-bit AXI-Stream against a golden stream, producing word count, checksum, mismatch, length, timeout and a pass/fail verdict
module axis_golden_checker #(
  parameter int WIDTH          = 64,
  parameter int EXPECTED_WORDS = 4881,
  parameter int TIMEOUT_CYCLES = 220000,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     dut_data,
  input  logic                 dut_valid,
  input  logic                 dut_last,
  output logic                 dut_ready,
  input  logic [WIDTH-1:0]     ref_data,
  input  logic                 ref_valid,
  output logic                 ref_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic                 length_error,
  output logic                 timeout,
  output logic [CNT_WIDTH-1:0] word_count,
  output logic [CNT_WIDTH-1:0] mismatch_count,
  output logic [CNT_WIDTH-1:0] first_mismatch_idx,
  output logic [WIDTH-1:0]     checksum
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] EXP_LAST = CNT_WIDTH'(EXPECTED_WORDS);
  localparam logic [CNT_WIDTH-1:0] STALL_MAX = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  logic [1:0] state;
  logic [CNT_WIDTH-1:0] stall;
  logic beat, mm, at_end, len_bad;
  logic [CNT_WIDTH-1:0] wc_next;
  always_comb begin
    busy      = state == RUN;
    beat      = busy && dut_valid && ref_valid;
    dut_ready = beat;
    ref_ready = beat;
    pass      = done && !fail;
    mm        = dut_data != ref_data;
    wc_next   = word_count + ONE;
    at_end    = wc_next == EXP_LAST;
    len_bad   = dut_last != at_end;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      done               <= 1'b0;
      fail               <= 1'b0;
      length_error       <= 1'b0;
      timeout            <= 1'b0;
      word_count         <= '0;
      mismatch_count     <= '0;
      first_mismatch_idx <= '0;
      checksum           <= '0;
      stall              <= '0;
    end else if (state != RUN) begin
      if (start) begin
        state              <= RUN;
        done               <= 1'b0;
        fail               <= 1'b0;
        length_error       <= 1'b0;
        timeout            <= 1'b0;
        word_count         <= '0;
        mismatch_count     <= '0;
        first_mismatch_idx <= '0;
        checksum           <= '0;
        stall              <= '0;
      end
    end else if (beat) begin
      word_count <= wc_next;
      checksum   <= checksum + dut_data;
      stall      <= '0;
      if (mm) begin
        fail <= 1'b1;
        if (mismatch_count != '1) mismatch_count <= mismatch_count + ONE;
        if (mismatch_count == '0) first_mismatch_idx <= word_count;
      end
      if (len_bad) begin
        length_error <= 1'b1;
        fail         <= 1'b1;
      end
      if (dut_last || at_end) begin
        state <= DONE;
        done  <= 1'b1;
      end
    end else if (stall == STALL_MAX) begin
      timeout <= 1'b1;
      fail    <= 1'b1;
      state   <= DONE;
      done    <= 1'b1;
    end else begin
      stall <= stall + ONE;
    end
  end
endmodule

// File: tb/tb_axis_golden_checker.sv
// tb_axis_golden_checker: table-driven and directed self-check of axis_golden_checker with 8-word streams and a 16-cycle stall limit
module tb_axis_golden_checker;
  logic clk = 0, rst = 1, start = 0;
  logic [63:0] dut_data = 0, ref_data = 0, checksum;
  logic dut_valid = 0, ref_valid = 0, dut_last = 0, dut_ready, ref_ready;
  logic busy, done, pass, fail, length_error, timeout;
  logic [31:0] word_count, mismatch_count, first_mismatch_idx;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  axis_golden_checker #(.WIDTH(64), .EXPECTED_WORDS(8), .TIMEOUT_CYCLES(16), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start),
    .dut_data(dut_data), .dut_valid(dut_valid), .dut_last(dut_last), .dut_ready(dut_ready),
    .ref_data(ref_data), .ref_valid(ref_valid), .ref_ready(ref_ready),
    .busy(busy), .done(done), .pass(pass), .fail(fail), .length_error(length_error), .timeout(timeout),
    .word_count(word_count), .mismatch_count(mismatch_count), .first_mismatch_idx(first_mismatch_idx),
    .checksum(checksum)
  );
  typedef struct {
    string name;
    int ca;
    int cb;
    int last_pos;
    bit bp;
    int wc;
    int mm;
    int fi;
    bit le;
    bit ps;
    logic [63:0] cs;
  } vec_t;
  vec_t vecs[7];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic pulse_start();
    @(negedge clk);
    start = 1;
    @(posedge clk);
    @(negedge clk);
    start = 0;
  endtask
  task automatic drive_word(input int i, input int ca, input int cb, input int last_pos);
    dut_data = 64'(i + 1);
    if (i == ca || i == cb) dut_data[0] = ~dut_data[0];
    ref_data = 64'(i + 1);
    dut_last = (i + 1 == last_pos);
  endtask
  task automatic beats(input int base, input int n);
    for (int k = 0; k < n; k++) begin
      dut_valid = 1;
      ref_valid = 1;
      drive_word(base + k, -1, -1, 8);
      @(posedge clk);
      @(negedge clk);
    end
    dut_valid = 0;
    ref_valid = 0;
  endtask
  task automatic run_vec(input vec_t v);
    int i = 0, cyc = 0, last_beat = -100, rdy_bad = 0;
    logic b;
    pulse_start();
    while (!done && cyc < 300) begin
      dut_valid = v.bp ? 1'($urandom_range(0, 1)) : 1'b1;
      ref_valid = v.bp ? 1'($urandom_range(0, 1)) : 1'b1;
      drive_word(i, v.ca, v.cb, v.last_pos);
      #1;
      b = dut_valid && ref_valid;
      if (dut_ready !== b || ref_ready !== b) rdy_bad++;
      @(posedge clk);
      if (b) begin
        i++;
        last_beat = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    dut_valid = 0;
    ref_valid = 0;
    chk({v.name, " done"}, 64'(done), 1);
    chk({v.name, " done_latency"}, 64'(cyc - last_beat), 1);
    chk({v.name, " busy"}, 64'(busy), 0);
    chk({v.name, " ready_join"}, 64'(rdy_bad), 0);
    chk({v.name, " word_count"}, 64'(word_count), 64'(v.wc));
    chk({v.name, " checksum"}, checksum, v.cs);
    chk({v.name, " mismatch_count"}, 64'(mismatch_count), 64'(v.mm));
    if (v.mm != 0) chk({v.name, " first_mismatch_idx"}, 64'(first_mismatch_idx), 64'(v.fi));
    chk({v.name, " length_error"}, 64'(length_error), 64'(v.le));
    chk({v.name, " pass"}, 64'(pass), 64'(v.ps));
    chk({v.name, " fail"}, 64'(fail), 64'(!v.ps));
    chk({v.name, " timeout"}, 64'(timeout), 0);
  endtask
  initial begin
    int n;
    vecs[0] = '{"matched",   -1, -1, 8, 0, 8, 0, 0, 0, 1, 64'd36};
    vecs[1] = '{"corrupt3",   3, -1, 8, 0, 8, 1, 3, 0, 0, 64'd37};
    vecs[2] = '{"early_last",-1, -1, 5, 0, 5, 0, 0, 1, 0, 64'd15};
    vecs[3] = '{"no_last",   -1, -1, 0, 0, 8, 0, 0, 1, 0, 64'd36};
    vecs[4] = '{"corrupt0_6", 0,  6, 8, 0, 8, 2, 0, 0, 0, 64'd34};
    vecs[5] = '{"backpress", -1, -1, 8, 1, 8, 0, 0, 0, 1, 64'd36};
    vecs[6] = '{"rerun",     -1, -1, 8, 0, 8, 0, 0, 0, 1, 64'd36};
    dut_valid = 1;
    ref_valid = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    chk("reset busy", 64'(busy), 0);
    chk("reset done", 64'(done), 0);
    chk("reset dut_ready", 64'(dut_ready), 0);
    chk("reset ref_ready", 64'(ref_ready), 0);
    chk("reset word_count", 64'(word_count), 0);
    chk("reset checksum", checksum, 0);
    chk("reset fail", 64'(fail), 0);
    dut_valid = 0;
    ref_valid = 0;
    pulse_start();
    beats(0, 3);
    dut_valid = 1;
    ref_valid = 1;
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    chk("rst_mid busy", 64'(busy), 0);
    chk("rst_mid dut_ready", 64'(dut_ready), 0);
    chk("rst_mid ref_ready", 64'(ref_ready), 0);
    chk("rst_mid word_count", 64'(word_count), 0);
    dut_valid = 0;
    ref_valid = 0;
    pulse_start();
    beats(0, 3);
    pulse_start();
    chk("start_in_run word_count", 64'(word_count), 3);
    chk("start_in_run busy", 64'(busy), 1);
    beats(3, 5);
    chk("start_in_run done", 64'(done), 1);
    chk("start_in_run pass", 64'(pass), 1);
    pulse_start();
    beats(0, 2);
    dut_valid = 1;
    ref_valid = 0;
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n = k;
        break;
      end
    end
    dut_valid = 0;
    chk("timeout cycles", 64'(n), 16);
    chk("timeout flag", 64'(timeout), 1);
    chk("timeout fail", 64'(fail), 1);
    chk("timeout length_error", 64'(length_error), 0);
    chk("timeout word_count", 64'(word_count), 2);
    pulse_start();
    chk("clear done", 64'(done), 0);
    chk("clear fail", 64'(fail), 0);
    chk("clear timeout", 64'(timeout), 0);
    chk("clear word_count", 64'(word_count), 0);
    chk("clear busy", 64'(busy), 1);
    for (int v = 0; v < 7; v++) run_vec(vecs[v]);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
